// File: rtl/fir_decim_fifo_if.sv
// Bundles the sample input, the control inputs and the decimated FIFO output of
// fir_decim_fifo. The slave modport is the DUT view; the master modport is the driver view.
interface fir_decim_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic                         in_en;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic [3:0]                   decim_m;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [FILL_W-1:0]            fill;
  logic                         overflow;
  logic                         clr_ovf;

  modport slave (
    input  in_en, data_in, decim_m, m_ready, clr_ovf,
    output m_valid, m_data, fill, overflow
  );

  modport master (
    output in_en, data_in, decim_m, m_ready, clr_ovf,
    input  m_valid, m_data, fill, overflow
  );
endinterface

// File: rtl/fir_decim_fifo.sv
// Discards FIR pipeline warm-up samples, keeps every M-th sample and buffers the
// kept samples in a FIFO whose head is presented through a registered output.
module fir_decim_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int WARMUP     = 3
) (
  input  logic           clk,
  input  logic           reset,
  fir_decim_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic {WARM, RUN} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_warm_cnt, w_warm_cnt_next;
  logic [3:0]            r_phase, w_phase_next;
  logic [3:0]            r_m, w_m_next, w_m_in;
  logic                  w_keep;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_inc;
  logic [FW-1:0]         r_fill, w_fill_next;
  logic                  r_valid, r_ovf;
  logic [DATA_WIDTH-1:0] r_head, w_head_next;
  logic                  w_pop, w_push, w_drop, w_full;

  assign w_m_in = (bus.decim_m == 4'd0) ? 4'd1 : bus.decim_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WARM;
      r_warm_cnt <= '0;
      r_phase    <= '0;
      r_m        <= 4'd1;
    end else begin
      r_state    <= w_state_next;
      r_warm_cnt <= w_warm_cnt_next;
      r_phase    <= w_phase_next;
      r_m        <= w_m_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_warm_cnt_next = r_warm_cnt;
    w_phase_next    = r_phase;
    w_m_next        = r_m;
    w_keep          = 1'b0;
    case (r_state)
      WARM: begin
        if (bus.in_en) begin
          if (r_warm_cnt == CW'(WARMUP - 1)) begin
            w_state_next    = RUN;
            w_warm_cnt_next = '0;
            w_phase_next    = '0;
            w_m_next        = w_m_in;
          end else begin
            w_warm_cnt_next = r_warm_cnt + CW'(1);
          end
        end
      end
      RUN: begin
        if (!bus.in_en) begin
          // A gap in the sample stream means the filter restarted.
          w_state_next    = WARM;
          w_warm_cnt_next = '0;
          w_phase_next    = '0;
        end else if (r_phase == 4'd0) begin
          w_keep       = 1'b1;
          w_m_next     = w_m_in;
          w_phase_next = (w_m_in == 4'd1) ? 4'd0 : 4'd1;
        end else begin
          w_phase_next = (r_phase == r_m - 4'd1) ? 4'd0 : r_phase + 4'd1;
        end
      end
      default: w_state_next = WARM;
    endcase
  end

  assign w_pop       = r_valid & bus.m_ready;
  assign w_full      = (r_fill == FW'(DEPTH));
  assign w_push      = w_keep & (~w_full | w_pop);
  assign w_drop      = w_keep & w_full & ~w_pop;
  assign w_fill_next = r_fill + FW'(w_push) - FW'(w_pop);
  assign w_rd_inc    = r_rd_ptr + AW'(1);

  // Next head: the entry behind the current head, or the incoming sample when it
  // lands in an otherwise empty FIFO.
  always_comb begin
    w_head_next = r_head;
    if (w_pop) begin
      if (r_fill == FW'(1)) begin
        if (w_push) w_head_next = bus.data_in;
      end else begin
        w_head_next = r_mem[w_rd_inc];
      end
    end else if (r_fill == '0 && w_push) begin
      w_head_next = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      r_fill  <= w_fill_next;
      r_valid <= (w_fill_next != '0);
      r_head  <= w_head_next;
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.m_valid  = r_valid;
  assign bus.m_data   = r_head;
  assign bus.fill     = r_fill;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: expected kept samples are queued at issue time
// and a negedge monitor compares every accepted output against the queue.
module tb_fir_decim_fifo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_decim_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

  fir_decim_fifo #(.DATA_WIDTH(16), .DEPTH(8), .WARMUP(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; exp_push queues the sample as an expected output.
  task automatic step(input logic en, input logic [15:0] d, input logic [3:0] dm,
                      input logic rdy, input logic clr, input bit exp_push);
    bus.in_en   = en;
    bus.data_in = d;
    bus.decim_m = dm;
    bus.m_ready = rdy;
    bus.clr_ovf = clr;
    if (exp_push) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic warm(input logic [3:0] dm, input logic rdy);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, dm, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: an output transfer happens on the edge following this negedge.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: actual=0x%0h required=none", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", int'(bus.m_data), int'(e));
          $display("pop data=0x%04h expected=0x%04h", bus.m_data, e);
        end
      end
    end
  end

  logic [15:0] t6_data [9];
  logic [3:0]  t6_dm   [9];
  bit          t6_keep [9];

  initial begin
    reset       = 1'b1;
    bus.in_en   = 1'b0;
    bus.data_in = '0;
    bus.decim_m = 4'd1;
    bus.m_ready = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fill", int'(bus.fill), 0);
    check("reset_m_valid", int'(bus.m_valid), 0);
    check("reset_m_data", int'(bus.m_data), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    reset = 1'b0;

    // Warm-up discard and one-cycle latency.
    step(1'b1, 16'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    check("warm_discard_fill", int'(bus.fill), 0);
    step(1'b1, 16'd4, 4'd1, 1'b1, 1'b0, 1'b1);
    check("latency_valid_4", int'(bus.m_valid), 1);
    check("latency_data_4", int'(bus.m_data), 4);
    step(1'b1, 16'd5, 4'd1, 1'b1, 1'b0, 1'b1);
    check("latency_data_5", int'(bus.m_data), 5);
    idle(2);
    check("t1_drained_fill", int'(bus.fill), 0);

    // Decimate by 4.
    warm(4'd4, 1'b1);
    for (int i = 0; i < 12; i++)
      step(1'b1, 16'h0010 + 16'(i), 4'd4, 1'b1, 1'b0, (i % 4) == 0);
    idle(2);
    check("t2_drained_fill", int'(bus.fill), 0);

    // Fill to DEPTH with no consumer, overflow on the extra samples.
    warm(4'd1, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h0100 + 16'(i), 4'd1, 1'b0, 1'b0, i < 8);
    check("t3_full_fill", int'(bus.fill), 8);
    check("t3_overflow_set", int'(bus.overflow), 1);
    check("t3_head_stable", int'(bus.m_data), 'h100);
    step(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    check("t3_overflow_clr", int'(bus.overflow), 0);
    check("t3_fill_after_clr", int'(bus.fill), 8);
    idle(9);
    check("t3_drained_fill", int'(bus.fill), 0);
    check("t3_drained_valid", int'(bus.m_valid), 0);

    // Full FIFO with simultaneous push/pop, then pointer wrap.
    warm(4'd1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'h0200 + 16'(i), 4'd1, 1'b0, 1'b0, 1'b1);
    check("t4_full_fill", int'(bus.fill), 8);
    step(1'b1, 16'h0208, 4'd1, 1'b1, 1'b0, 1'b1);
    check("t4_pushpop_fill", int'(bus.fill), 8);
    check("t4_pushpop_no_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 16'h0209 + 16'(i), 4'd1, 1'b1, 1'b0, 1'b1);
    check("t4_wrap_fill", int'(bus.fill), 8);
    check("t4_wrap_no_ovf", int'(bus.overflow), 0);
    step(1'b1, 16'h021D, 4'd1, 1'b0, 1'b1, 1'b0);
    check("t4_set_wins", int'(bus.overflow), 1);
    step(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    check("t4_clr", int'(bus.overflow), 0);
    idle(9);
    check("t4_drained_fill", int'(bus.fill), 0);

    // Restart on in_en gap: warm-up repeats and phase restarts at 0.
    warm(4'd2, 1'b1);
    step(1'b1, 16'h0300, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0310 + 16'(i), 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0313, 4'd2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0314, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0315, 4'd2, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("t5_drained_fill", int'(bus.fill), 0);

    // Reset with five entries held, asserted alongside every other control.
    warm(4'd1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0400 + 16'(i), 4'd1, 1'b0, 1'b0, 1'b0);
    check("t5_fill5", int'(bus.fill), 5);
    reset = 1'b1;
    step(1'b1, 16'h0405, 4'd1, 1'b1, 1'b1, 1'b0);
    check("t5_reset_fill", int'(bus.fill), 0);
    check("t5_reset_valid", int'(bus.m_valid), 0);
    check("t5_reset_data", int'(bus.m_data), 0);
    reset = 1'b0;
    step(1'b0, 16'h0, 4'd1, 1'b0, 1'b0, 1'b0);

    // decim_m changed 2->3 mid-period.
    t6_data = '{16'h0500, 16'h0501, 16'h0502, 16'h0503, 16'h0504,
                16'h0505, 16'h0506, 16'h0507, 16'h0508};
    t6_dm   = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    t6_keep = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    warm(4'd2, 1'b1);
    for (int i = 0; i < 9; i++)
      step(1'b1, t6_data[i], t6_dm[i], 1'b1, 1'b0, t6_keep[i]);
    idle(3);
    check("t6_drained_fill", int'(bus.fill), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
